pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_md_timer.sv | 38 +++
 rtl/pipe_ctrl.sv | 90 +++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control block:
// FSM states, PC select codes, multiply/divide latencies and the handler address.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        GUARD = 1'b1
    } state_e;

    localparam logic [1:0] PC_SEQ     = 2'd0;
    localparam logic [1:0] PC_HANDLER = 2'd1;
    localparam logic [1:0] PC_EPC     = 2'd2;

    localparam logic [3:0] MD_LAT_MULT = 4'd5;
    localparam logic [3:0] MD_LAT_DIV  = 4'd10;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Busy window of the multi-cycle HI/LO unit: loads its latency on an
// accepted start and counts down to idle; a flush never cancels a running count.
module md_timer
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic type_i,
    input  logic flush_i,
    output logic busy_o
);

    logic [3:0] md_cnt_q;
    logic [3:0] md_cnt_d;
    logic       accept;

    assign busy_o = (md_cnt_q != 4'd0);
    assign accept = start_i && !busy_o && !flush_i;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (accept) begin
            md_cnt_d = type_i ? MD_LAT_DIV : MD_LAT_MULT;
        end else if (busy_o) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard detection, stall/flush generation and exception/eret redirect
// for a 5-stage pipeline, plus a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  e_wa,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        d_md,
    input  logic        e_md_start,
    input  logic        e_md_type,
    input  logic        exc_req,
    input  logic        eret_m,
    output logic        noen_pc,
    output logic        noen_d,
    output logic        flush_e,
    output logic        flush_all,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    state_e      state_q;
    logic [31:0] stall_cnt_q;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        hazard_md;
    logic        stall;
    logic        run;
    logic        exc_take;
    logic        eret_take;
    logic        hold;

    assign hazard_rs = (d_rs != 5'd0) &&
                       (((e_wa == d_rs) && (e_tnew > d_tuse_rs)) ||
                        ((m_wa == d_rs) && (m_tnew > d_tuse_rs)));
    assign hazard_rt = (d_rt != 5'd0) &&
                       (((e_wa == d_rt) && (e_tnew > d_tuse_rt)) ||
                        ((m_wa == d_rt) && (m_tnew > d_tuse_rt)));
    assign hazard_md = d_md && (md_busy || e_md_start);
    assign stall     = hazard_rs || hazard_rt || hazard_md;

    // Outputs are combinational in the inputs, so gate them with reset
    // to keep them quiet while reset is held.
    assign run       = (state_q == RUN) && reset;
    assign exc_take  = run && exc_req;
    assign eret_take = run && eret_m && !exc_req;
    assign flush_all = exc_take || eret_take;
    assign hold      = stall && !flush_all && reset;

    assign noen_pc   = hold;
    assign noen_d    = hold;
    assign flush_e   = hold;
    assign pc_sel    = exc_take  ? PC_HANDLER :
                       eret_take ? PC_EPC     : PC_SEQ;
    assign stall_cnt = stall_cnt_q;

    md_timer u_md_timer (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (e_md_start),
        .type_i  (e_md_type),
        .flush_i (flush_all),
        .busy_o  (md_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= 32'd0;
        end else begin
            unique case (state_q)
                RUN:     if (flush_all) state_q <= GUARD;
                GUARD:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
            if (noen_pc && (stall_cnt_q != STALL_CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl: hazard vectors plus
// hand-written MD-window, exception/eret, flush and reset sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_md, e_md_start, e_md_type, exc_req, eret_m;
    logic        noen_pc, noen_d, flush_e, flush_all, md_busy;
    logic [1:0]  pc_sel;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .e_wa       (e_wa),
        .m_wa       (m_wa),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .d_md       (d_md),
        .e_md_start (e_md_start),
        .e_md_type  (e_md_type),
        .exc_req    (exc_req),
        .eret_m     (eret_m),
        .noen_pc    (noen_pc),
        .noen_d     (noen_d),
        .flush_e    (flush_e),
        .flush_all  (flush_all),
        .pc_sel     (pc_sel),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [4:0] rs, rt, ewa, mwa;
        logic [1:0] trs, trt, etn, mtn;
        logic       md;
        logic       stall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
        e_wa = 0; m_wa = 0; e_tnew = 0; m_tnew = 0;
        d_md = 0; e_md_start = 0; e_md_type = 0;
        exc_req = 0; eret_m = 0;
    endtask

    task automatic load_use();
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        load_use();
        exc_req = 1'b1;
        d_md = 1'b1;
        e_md_start = 1'b1;
        #3;
        chk("rst_noen_pc", noen_pc, 0);
        chk("rst_flush_all", flush_all, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy_held", md_busy, 0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        tick();

        vecs[0] = '{8, 0, 8, 0, 0, 3, 1, 0, 0, 1};
        vecs[1] = '{0, 0, 0, 0, 0, 3, 2, 0, 0, 0};
        vecs[2] = '{8, 0, 8, 0, 1, 3, 1, 0, 0, 0};
        vecs[3] = '{0, 9, 0, 9, 3, 0, 0, 1, 0, 1};
        vecs[4] = '{5, 0, 5, 0, 3, 3, 2, 0, 0, 0};
        vecs[5] = '{5, 0, 6, 0, 0, 3, 2, 0, 0, 0};
        vecs[6] = '{0, 7, 7, 0, 3, 1, 2, 0, 0, 1};
        vecs[7] = '{0, 4, 0, 4, 3, 0, 0, 2, 0, 1};
        vecs[8] = '{0, 0, 0, 0, 3, 3, 0, 0, 1, 0};

        for (int i = 0; i < 9; i++) begin
            d_rs = vecs[i].rs; d_rt = vecs[i].rt;
            e_wa = vecs[i].ewa; m_wa = vecs[i].mwa;
            d_tuse_rs = vecs[i].trs; d_tuse_rt = vecs[i].trt;
            e_tnew = vecs[i].etn; m_tnew = vecs[i].mtn;
            d_md = vecs[i].md;
            @(negedge clk);
            chk($sformatf("vec%0d_noen_pc", i), noen_pc, vecs[i].stall);
            chk($sformatf("vec%0d_noen_d", i), noen_d, vecs[i].stall);
            chk($sformatf("vec%0d_flush_e", i), flush_e, vecs[i].stall);
            chk($sformatf("vec%0d_pc_sel", i), pc_sel, 0);
            tick();
            if (vecs[i].stall) exp_cnt++;
            chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, exp_cnt);
        end
        idle_inputs();

        // div window; a mult start mid-window must be ignored
        e_md_start = 1; e_md_type = 1;
        @(negedge clk);
        chk("div_start_busy", md_busy, 0);
        chk("div_start_noen", noen_pc, 0);
        tick();
        e_md_start = 0; e_md_type = 0; d_md = 1;
        for (int i = 1; i <= 10; i++) begin
            e_md_start = (i == 3);
            @(negedge clk);
            chk($sformatf("div_busy_c%0d", i), md_busy, 1);
            chk($sformatf("div_stall_c%0d", i), noen_pc, 1);
            tick();
            exp_cnt++;
        end
        e_md_start = 0;
        @(negedge clk);
        chk("div_release_busy", md_busy, 0);
        chk("div_release_noen", noen_pc, 0);
        tick();
        chk("div_stall_cnt", stall_cnt, exp_cnt);
        idle_inputs();

        // exc + eret together with a pending stall
        load_use();
        exc_req = 1; eret_m = 1;
        @(negedge clk);
        chk("both_flush_all", flush_all, 1);
        chk("both_pc_sel", pc_sel, 1);
        chk("both_noen_pc", noen_pc, 0);
        chk("both_flush_e", flush_e, 0);
        tick();
        eret_m = 0;
        @(negedge clk);
        chk("guard_flush_all", flush_all, 0);
        chk("guard_pc_sel", pc_sel, 0);
        chk("guard_noen_pc", noen_pc, 1);
        tick();
        exp_cnt++;
        chk("guard_stall_cnt", stall_cnt, exp_cnt);
        idle_inputs();
        eret_m = 1;
        @(negedge clk);
        chk("eret_flush_all", flush_all, 1);
        chk("eret_pc_sel", pc_sel, 2);
        tick();
        idle_inputs();
        tick();

        // flush in the same cycle as an MD start
        exc_req = 1; e_md_start = 1; e_md_type = 0;
        @(negedge clk);
        chk("flmd_flush_all", flush_all, 1);
        tick();
        idle_inputs();
        chk("flmd_md_busy", md_busy, 0);
        tick();
        chk("flmd_md_busy2", md_busy, 0);

        // mult running through a flush, then reset mid-operation in GUARD
        e_md_start = 1; e_md_type = 0;
        tick();
        idle_inputs();
        exc_req = 1;
        @(negedge clk);
        chk("mult_flush_all", flush_all, 1);
        tick();
        chk("mult_busy_after_flush", md_busy, 1);
        exc_req = 0;
        load_use();
        d_md = 1;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_noen_pc", noen_pc, 0);
        chk("midrst_flush_e", flush_e, 0);
        chk("midrst_md_busy", md_busy, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        exp_cnt = 0;
        idle_inputs();
        reset = 1'b1;
        exc_req = 1;
        #1;
        chk("midrst_state_run", flush_all, 1);
        chk("midrst_pc_sel", pc_sel, 1);
        tick();
        idle_inputs();
        tick();
        chk("final_stall_cnt", stall_cnt, exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
